// File: rtl/div_arb_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } div_arb_state_t;

    localparam int DIV_ARB_TIMEOUT_CYCLES = 64;
    localparam int DIV_ARB_MAX_W          = 64;

    // All-ones pattern of the requested width, used as the divide-by-zero quotient.
    function automatic logic [DIV_ARB_MAX_W-1:0] div_arb_zero_quot(input int unsigned width);
        logic [DIV_ARB_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DIV_ARB_MAX_W; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_idx     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among NUM_REQ requesters: accept, clear, issue,
// wait (with timeout) and return quotient/remainder/error to the winner.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = DIV_ARB_TIMEOUT_CYCLES
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [NUM_REQ-1:0]                       resp_valid,
    output logic [DIVIDEND_WIDTH-1:0]                resp_quotient,
    output logic [DIVISOR_WIDTH-1:0]                 resp_remainder,
    output logic                                     resp_error,
    output logic                                     busy,
    output logic                                     div_reset,
    output logic [DIVIDEND_WIDTH-1:0]                div_dividend,
    output logic [DIVISOR_WIDTH-1:0]                 div_divisor,
    output logic                                     div_valid_in,
    input  logic [DIVIDEND_WIDTH-1:0]                div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]                 div_remainder,
    input  logic                                     div_valid_out,
    input  logic                                     div_overflow,
    output div_arb_state_t                           dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] ZERO_QUOT = DIVIDEND_WIDTH'(div_arb_zero_quot(DIVIDEND_WIDTH));

    div_arb_state_t              r_state;
    logic [IDX_W-1:0]            r_grant_idx;
    logic [IDX_W-1:0]            r_last_grant;
    logic [DIVIDEND_WIDTH-1:0]   r_dividend;
    logic [DIVISOR_WIDTH-1:0]    r_divisor;
    logic [DIVIDEND_WIDTH-1:0]   r_quot;
    logic [DIVISOR_WIDTH-1:0]    r_rem;
    logic                        r_err;
    logic [CNT_W-1:0]            r_wait_cnt;

    logic [NUM_REQ-1:0]          w_grant;
    logic [IDX_W-1:0]            w_grant_idx;
    logic                        w_any;
    logic [NUM_REQ-1:0]          w_resp_oh;
    logic                        w_issue;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any        (w_any)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_idx  <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_dividend   <= req_dividend[w_grant_idx];
                        r_divisor    <= req_divisor[w_grant_idx];
                        r_wait_cnt   <= '0;
                        // A zero divisor is answered locally and never reaches the divider.
                        if (req_divisor[w_grant_idx] == '0) begin
                            r_quot  <= ZERO_QUOT;
                            r_rem   <= '0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: r_state <= BUSY;
                BUSY: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    if (div_valid_out) begin
                        r_quot  <= div_quotient;
                        r_rem   <= div_remainder;
                        r_err   <= div_overflow;
                        r_state <= RESP;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_wait_cnt <= '0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_resp_oh              = '0;
        w_resp_oh[r_grant_idx] = 1'b1;
    end

    // Reset gating keeps strobes quiet and the divider cleared while reset is low.
    assign w_issue        = reset && ((r_state == LOAD) || (r_state == BUSY));
    assign req_ready      = (reset && r_state == IDLE) ? w_grant : '0;
    assign resp_valid     = (reset && r_state == RESP) ? w_resp_oh : '0;
    assign resp_quotient  = r_quot;
    assign resp_remainder = r_rem;
    assign resp_error     = r_err;
    assign busy           = (r_state != IDLE);
    assign div_reset      = !reset || (r_state == LOAD);
    assign div_valid_in   = reset && (r_state == BUSY);
    assign div_dividend   = w_issue ? r_dividend : '0;
    assign div_divisor    = w_issue ? r_divisor : '0;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a transaction-level reference model and a
// 3-cycle divider model that can be muted (timeout) or forced to flag overflow.
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int VW = 32;
    localparam int TO = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0][DW-1:0]  req_dividend = '0;
    logic [N-1:0][VW-1:0]  req_divisor = '0;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          resp_valid;
    logic [DW-1:0]         resp_quotient;
    logic [VW-1:0]         resp_remainder;
    logic                  resp_error;
    logic                  busy;
    logic                  div_reset;
    logic [DW-1:0]         div_dividend;
    logic [VW-1:0]         div_divisor;
    logic                  div_valid_in;
    logic [DW-1:0]         div_quotient;
    logic [VW-1:0]         div_remainder;
    logic                  div_valid_out;
    logic                  div_overflow;
    div_arb_state_t        dbg_state;

    div_arbiter #(
        .NUM_REQ        (N),
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (VW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_error     (resp_error),
        .busy           (busy),
        .div_reset      (div_reset),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_valid_in   (div_valid_in),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .div_valid_out  (div_valid_out),
        .div_overflow   (div_overflow),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clock = ~clock;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= !reset;
    end

    // ---------------- divider model: result on 3rd issue cycle ----------------
    logic dm_en    = 1'b1;
    logic dm_ovf   = 1'b0;
    logic dm_stale = 1'b0;
    int   dm_cnt   = 0;

    always @(posedge clock) begin
        if (div_reset)         dm_cnt <= 0;
        else if (div_valid_in) dm_cnt <= dm_cnt + 1;
    end

    assign div_valid_out = dm_stale || (dm_en && div_valid_in && dm_cnt == 2);
    assign div_quotient  = (div_divisor != 0) ? div_dividend / div_divisor : '1;
    assign div_remainder = (div_divisor != 0) ? div_dividend % div_divisor : '0;
    assign div_overflow  = dm_ovf;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  idx;
        logic        zero;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] quot;
        logic [31:0] rem;
        logic        err;
        int          acc;
        int          due;
    } exp_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] quot;
        logic [31:0] rem;
        logic        err;
        int          cyc;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_log[$];
    int    grant_log[$];
    int    grant_cyc[$];
    int    ptr = N - 1;
    int    last_div_reset_cyc = -1;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] oh);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (oh[i]) r = i;
        return r;
    endfunction

    // One model step per cycle: who must be granted, what the divider side must
    // see, and when/what the response must be.
    task automatic model_cycle();
        logic [N-1:0] exp_ready;
        int           g;
        int           j;
        exp_t         e;
        exp_t         ne;
        resp_t        r;
        logic         in_load;
        logic         in_issue;
        exp_ready = '0;
        g         = -1;
        e         = '0;
        in_load   = 1'b0;
        in_issue  = 1'b0;

        chk("busy", busy, exp_q.size() != 0);
        if (exp_q.size() == 0) begin
            for (int k = 1; k <= N; k++) begin
                j = (ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);

        if (exp_q.size() != 0) begin
            e        = exp_q[0];
            in_load  = !e.zero && (cyc == e.acc + 1);
            in_issue = !e.zero && (cyc >= e.acc + 2) && (cyc < e.due);
        end
        chk("div_reset", div_reset, in_load);
        chk("div_valid_in", div_valid_in, in_issue);
        chk("div_dividend", div_dividend, (in_load || in_issue) ? e.dvd : 32'd0);
        chk("div_divisor", div_divisor, (in_load || in_issue) ? e.dvs : 32'd0);
        if (div_reset) last_div_reset_cyc = cyc;

        if (exp_q.size() != 0 && cyc >= e.due) begin
            chk("resp_valid", resp_valid, 64'd1 << e.idx);
            chk("resp_quotient", resp_quotient, e.quot);
            chk("resp_remainder", resp_remainder, e.rem);
            chk("resp_error", resp_error, e.err);
            void'(exp_q.pop_front());
        end else begin
            chk("resp_valid_quiet", resp_valid, 0);
        end

        if (resp_valid != 0) begin
            r.idx  = 2'(oh2idx(resp_valid));
            r.quot = resp_quotient;
            r.rem  = resp_remainder;
            r.err  = resp_error;
            r.cyc  = cyc;
            resp_log.push_back(r);
        end
        if (req_ready != 0) begin
            grant_log.push_back(oh2idx(req_ready));
            grant_cyc.push_back(cyc);
        end

        if (g >= 0) begin
            ne.idx  = 2'(g);
            ne.dvd  = req_dividend[g];
            ne.dvs  = req_divisor[g];
            ne.zero = (req_divisor[g] == 0);
            ne.acc  = cyc;
            if (ne.zero) begin
                ne.due = cyc + 1; ne.quot = 32'hFFFF_FFFF; ne.rem = 0; ne.err = 1'b1;
            end else if (!dm_en) begin
                ne.due = cyc + 2 + TO; ne.quot = 0; ne.rem = 0; ne.err = 1'b1;
            end else begin
                ne.due = cyc + 5; ne.quot = ne.dvd / ne.dvs; ne.rem = ne.dvd % ne.dvs; ne.err = dm_ovf;
            end
            exp_q.push_back(ne);
            ptr = g;
        end
    endtask

    always @(negedge clock) begin
        if (rst_seen) begin
            exp_q.delete();
            ptr = N - 1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_quotient", resp_quotient, 0);
            chk("rst_resp_remainder", resp_remainder, 0);
            chk("rst_resp_error", resp_error, 0);
            chk("rst_busy", busy, 0);
            chk("rst_div_reset", div_reset, !reset);
            chk("rst_div_valid_in", div_valid_in, 0);
            chk("rst_div_dividend", div_dividend, 0);
            chk("rst_div_divisor", div_divisor, 0);
            chk("rst_state", dbg_state, IDLE);
        end else if (!reset) begin
            chk("rstlow_resp_valid", resp_valid, 0);
            chk("rstlow_req_ready", req_ready, 0);
            chk("rstlow_div_reset", div_reset, 1);
        end else begin
            model_cycle();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_req(input int idx, input logic [31:0] dvd, input logic [31:0] dvs);
        req_dividend[idx] = dvd;
        req_divisor[idx]  = dvs;
        req_valid[idx]    = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock); #1;
            if (req_ready[idx]) break;
        end
        chk("grant_seen", req_ready[idx], 1);
        @(posedge clock); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_resps(input int n);
        for (int t = 0; t < 300; t++) begin
            if (resp_log.size() >= n) break;
            @(negedge clock); #1;
        end
        chk("resp_count", resp_log.size(), n);
    endtask

    task automatic wait_grants(input int n);
        for (int t = 0; t < 300; t++) begin
            if (grant_log.size() >= n) break;
            @(negedge clock); #1;
        end
        chk("grant_count", grant_log.size(), n);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    // ---------------- directed stimulus ----------------
    int b;
    int n0;

    initial begin
        tick(4);
        reset = 1'b1;
        tick(2);

        // Single request: 1225 / 49 from requester 2.
        do_req(2, 32'd1225, 32'd49);
        wait_resps(1);
        chk("single_idx", resp_log[0].idx, 2);
        chk("single_quot", resp_log[0].quot, 25);
        chk("single_rem", resp_log[0].rem, 0);
        chk("single_err", resp_log[0].err, 0);
        chk("single_latency", resp_log[0].cyc - grant_cyc[0], 5);
        chk("single_div_reset_cyc", last_div_reset_cyc - grant_cyc[0], 1);

        // Divide by zero from requester 3.
        do_req(3, 32'd100, 32'd0);
        wait_resps(2);
        chk("dbz_idx", resp_log[1].idx, 3);
        chk("dbz_quot", resp_log[1].quot, 32'hFFFF_FFFF);
        chk("dbz_rem", resp_log[1].rem, 0);
        chk("dbz_err", resp_log[1].err, 1);
        chk("dbz_latency", resp_log[1].cyc - grant_cyc[1], 1);

        // Divider overflow flag propagates as error with the divider's data.
        dm_ovf = 1'b1;
        do_req(0, 32'd77, 32'd5);
        wait_resps(3);
        dm_ovf = 1'b0;
        chk("ovf_quot", resp_log[2].quot, 15);
        chk("ovf_rem", resp_log[2].rem, 2);
        chk("ovf_err", resp_log[2].err, 1);

        // Timeout: divider never answers.
        dm_en = 1'b0;
        do_req(1, 32'd500, 32'd7);
        wait_resps(4);
        dm_en = 1'b1;
        chk("to_latency", resp_log[3].cyc - grant_cyc[3], 10);
        chk("to_quot", resp_log[3].quot, 0);
        chk("to_err", resp_log[3].err, 1);
        do_req(2, 32'd90, 32'd9);
        wait_resps(5);
        chk("after_to_quot", resp_log[4].quot, 10);
        chk("after_to_err", resp_log[4].err, 0);

        // Fairness with all four held valid.
        pulse_reset();
        b = grant_log.size();
        for (int i = 0; i < N; i++) begin
            req_dividend[i] = 32'(100 * (i + 1) + i);
            req_divisor[i]  = 32'(i + 3);
        end
        req_valid = '1;
        wait_grants(b + 5);
        @(posedge clock); #1;
        req_valid = '0;
        chk("fair_0", grant_log[b + 0], 0);
        chk("fair_1", grant_log[b + 1], 1);
        chk("fair_2", grant_log[b + 2], 2);
        chk("fair_3", grant_log[b + 3], 3);
        chk("fair_4", grant_log[b + 4], 0);
        tick(12);

        // Fairness with requester 1 withdrawing before its turn.
        pulse_reset();
        b = grant_log.size();
        req_valid = '1;
        wait_grants(b + 1);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        wait_grants(b + 5);
        @(posedge clock); #1;
        req_valid = '0;
        chk("gap_0", grant_log[b + 0], 0);
        chk("gap_1", grant_log[b + 1], 2);
        chk("gap_2", grant_log[b + 2], 3);
        chk("gap_3", grant_log[b + 3], 0);
        chk("gap_4", grant_log[b + 4], 2);
        tick(12);

        // Reset in the middle of BUSY discards the transaction.
        n0 = resp_log.size();
        do_req(2, 32'd60, 32'd4);
        tick(1);
        chk("midbusy_issue", div_valid_in, 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(10);
        chk("midbusy_no_resp", resp_log.size(), n0);

        // Stale divider pulse in IDLE is ignored.
        dm_stale = 1'b1;
        tick(1);
        dm_stale = 1'b0;
        tick(2);
        chk("stale_busy", busy, 0);
        chk("stale_no_resp", resp_log.size(), n0);

        // Requester 0 wins first after reset, then 3.
        b = grant_log.size();
        req_dividend[0] = 32'd40; req_divisor[0] = 32'd8;
        req_dividend[3] = 32'd9;  req_divisor[3] = 32'd3;
        req_valid = 4'b1001;
        wait_grants(b + 1);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        wait_grants(b + 2);
        @(posedge clock); #1;
        req_valid = '0;
        chk("post_rst_first", grant_log[b + 0], 0);
        chk("post_rst_second", grant_log[b + 1], 3);
        wait_resps(n0 + 2);
        chk("post_rst_quot0", resp_log[n0].quot, 5);
        chk("post_rst_quot3", resp_log[n0 + 1].quot, 3);
        tick(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
